hex_ascii_stream_encoder: RTL and testbench
===========================================

Name: hex_ascii_stream_encoder

Overview:
- Converts one DATA_WIDTH-bit word into an AXI-Stream byte sequence of ASCII hex characters, MSB nibble first.
- Generalises the fixed 32-bit response coder with:
  - a parametrised data width;
  - an optional "0x" prefix;
  - optional leading-zero suppression;
  - upper- or lower-case digits;
  - a configurable line terminator;
  - a proper valid/ready input handshake and tlast framing.
- Sits between the bus response path (read data) and the UART TX stream.

Parameters:
- DATA_WIDTH, 32: input word width. Must be a multiple of 4, range 4..64. NIB = DATA_WIDTH/4.
- UPPERCASE, 0: 1 gives digits 'A'-'F' (0x41..0x46); 0 gives 'a'-'f' (0x61..0x66).
- PREFIX_EN, 0: 1 emits '0' (0x30) then 'x' (0x78) before the digits.
- ZERO_SUPPRESS, 0: 1 skips leading zero nibbles. At least one digit is always emitted.
- TERM_MODE, 1: 0 = no terminator; 1 = LF (0x0A); 2 = CR (0x0D) then LF (0x0A).

Ports:
- clk, input, 1: clock.
- reset, input, 1: asynchronous, active-high reset.
- s_valid, input, 1: input word valid.
- s_ready, output, 1: encoder can accept a word.
- s_data, input, DATA_WIDTH: word to encode.
- m_tvalid, output, 1: output byte valid.
- m_tdata, output, 8: ASCII byte.
- m_tlast, output, 1: final byte of the current word's sequence.
- m_tready, input, 1: downstream accepts the byte.
- busy, output, 1: a sequence is in progress (state != IDLE).

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - s_ready = 0, m_tvalid = 0, m_tdata = 0x00, m_tlast = 0, busy = 0, internal indices = 0.
  - s_ready rises on the first clk edge after reset deasserts.
- Reset mid-sequence aborts immediately. The partial sequence is discarded, never resumed.
- States: IDLE, PREFIX, DIGITS, TERM.
- All outputs are registered.
- IDLE:
  - s_ready = 1.
  - On s_valid && s_ready, capture s_data and drop s_ready.
  - Compute the first digit index:
    - ZERO_SUPPRESS = 0: index = NIB-1.
    - ZERO_SUPPRESS = 1: index = highest nonzero nibble; 0 if the word is zero.
  - Next state is PREFIX if PREFIX_EN, else DIGITS.
  - m_tvalid = 1 with the first byte on the next cycle (latency 1 clock from acceptance).
- Byte advance:
  - Only on m_tvalid && m_tready.
  - While m_tvalid && !m_tready, m_tdata and m_tlast hold stable. This is an AXI-Stream rule and is checked by assertion.
  - m_tvalid never drops before its handshake.
- PREFIX: emits 0x30, then 0x78, then goes to DIGITS.
- DIGITS:
  - Emits nibble[i] from index down to 0.
  - Nibble 0-9 maps to 0x30+n; 10-15 maps to base+(n-10), where base = 0x41 or 0x61.
  - After index 0, go to TERM, or finish if TERM_MODE = 0.
- TERM: emits 0x0A (mode 1), or 0x0D then 0x0A (mode 2).
- m_tlast is 1 only on the final byte of a sequence, whichever state produces it.
- Finishing:
  - On the final-byte handshake: m_tvalid = 0, m_tlast = 0, return to IDLE, s_ready = 1 on the next cycle.
  - There is no same-cycle back-to-back acceptance.
  - Throughput is 1 word per (bytes + 1) clocks when m_tready is held high.
- Sequence length = 2*PREFIX_EN + digits + {0,1,2}[TERM_MODE], where digits = NIB, or (index+1) when suppressed. Max 20 bytes for 64-bit.
- s_valid while not ready is ignored. The word is held by the source per handshake.
- m_tready asserted while m_tvalid = 0 has no effect.
- Illegal parameters (DATA_WIDTH % 4 != 0, TERM_MODE > 2) trigger an elaboration-time $error.

Test Plan:
- Defaults, s_data = 0xDEADBEEF, m_tready = 1 → bytes "deadbeef" then 0x0A, with tlast only on 0x0A; 9 consecutive tvalid cycles; s_ready returns 1 cycle after the last byte.
- UPPERCASE = 1, PREFIX_EN = 1, TERM_MODE = 2, s_data = 0x0000ABCD → "0x0000ABCD" then 0x0D 0x0A (12 bytes), with tlast on 0x0A.
- ZERO_SUPPRESS = 1:
  - s_data = 0x00000F00 → "f00\n".
  - s_data = 0x00000000 → "0\n" (a single digit).
- Random m_tready backpressure (~50%) on 0x12345678 → stream still equals "12345678\n"; m_tdata and m_tlast stable across every stalled cycle; s_ready stays 0 throughout; a second s_valid during the stall is not accepted.
- DATA_WIDTH = 8, TERM_MODE = 0, s_data = 0x7E → "7e", tlast on 'e'. Then DATA_WIDTH = 64 with 0x0123456789ABCDEF → 16 digits in order.
- Assert reset after the 3rd byte of 0xCAFEF00D → all outputs 0 immediately (asynchronously). After release, sending 0x11111111 gives a clean "11111111\n" with no leftover bytes.

Source files
------------

// File: rtl/hex_ascii_stream_encoder.sv
// ---------------------------------------------------------------------------
// hex_ascii_stream_encoder
//   Turns one DATA_WIDTH-bit word into an AXI-Stream sequence of ASCII hex
//   characters, most significant nibble first. The sequence can carry an
//   optional "0x" prefix, can suppress leading zeros, and ends with an
//   optional terminator: none, LF, or CR LF.
//
// Ports
//   clk       : clock
//   reset     : asynchronous, active-high reset
//   s_valid   : input word valid
//   s_ready   : encoder can accept a word (registered)
//   s_data    : word to encode
//   m_tvalid  : output byte valid (registered)
//   m_tdata   : ASCII byte (registered)
//   m_tlast   : last byte of the current word's sequence (registered)
//   m_tready  : downstream accepts the byte
//   busy      : a sequence is in progress (registered)
// ---------------------------------------------------------------------------
module hex_ascii_stream_encoder #(
    parameter int DATA_WIDTH    = 32,
    parameter int UPPERCASE     = 0,
    parameter int PREFIX_EN     = 0,
    parameter int ZERO_SUPPRESS = 0,
    parameter int TERM_MODE     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_tvalid,
    output logic [7:0]            m_tdata,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  busy
);

    localparam int NIB = DATA_WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [7:0] ALPHA_BASE = (UPPERCASE != 0) ? 8'h41 : 8'h61;

    if (((DATA_WIDTH % 4) != 0) || (DATA_WIDTH < 4) || (DATA_WIDTH > 64) ||
        (TERM_MODE < 0) || (TERM_MODE > 2)) begin : g_param_check
        $error("hex_ascii_stream_encoder: illegal DATA_WIDTH or TERM_MODE");
    end

    typedef enum logic [1:0] {IDLE, PREFIX, DIGITS, TERM} state_t;

    state_t                state_r;
    logic [DATA_WIDTH-1:0] word_r;
    logic [IW-1:0]         idx_r;    // current nibble index in DIGITS
    logic                  sub_r;    // second byte of PREFIX / TERM
    logic                  s_ready_r;
    logic                  m_tvalid_r;
    logic [7:0]            m_tdata_r;
    logic                  m_tlast_r;
    logic                  busy_r;

    // Nibble i of word w (variable index, unrolled into a mux).
    function automatic logic [3:0] nibble_at(input logic [DATA_WIDTH-1:0] w,
                                             input logic [IW-1:0] i);
        logic [3:0] n;
        n = 4'h0;
        for (int k = 0; k < NIB; k++) begin
            if (k == int'(i)) begin
                n = w[k*4 +: 4];
            end
        end
        return n;
    endfunction

    // ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return ALPHA_BASE + {4'h0, n} - 8'h0A;
        end
    endfunction

    // Index of the first digit to send; with suppression it is the highest
    // nonzero nibble, falling back to 0 so a zero word still prints "0".
    function automatic logic [IW-1:0] first_index(input logic [DATA_WIDTH-1:0] w);
        logic [IW-1:0] i;
        if (ZERO_SUPPRESS == 0) begin
            i = IW'(NIB - 1);
        end else begin
            i = '0;
            for (int k = 0; k < NIB; k++) begin
                if (w[k*4 +: 4] != 4'h0) begin
                    i = IW'(k);
                end
            end
        end
        return i;
    endfunction

    // Byte and last flag belonging to a sequence position: {last, data}.
    function automatic logic [8:0] pos_byte(input state_t st,
                                            input logic [IW-1:0] i,
                                            input logic sb,
                                            input logic [DATA_WIDTH-1:0] w);
        logic [8:0] r;
        case (st)
            PREFIX:  r = {1'b0, (sb ? 8'h78 : 8'h30)};
            DIGITS:  r = {((i == '0) && (TERM_MODE == 0)), hex_char(nibble_at(w, i))};
            TERM: begin
                if ((TERM_MODE == 2) && !sb) begin
                    r = {1'b0, 8'h0D};
                end else begin
                    r = {1'b1, 8'h0A};
                end
            end
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    state_t        first_state_s;
    logic [IW-1:0] first_idx_s;
    logic [8:0]    first_byte_s;
    state_t        adv_state_s;
    logic [IW-1:0] adv_idx_s;
    logic          adv_sub_s;
    logic [8:0]    adv_byte_s;

    // Position and byte used when a new word is accepted.
    always_comb begin
        first_state_s = (PREFIX_EN != 0) ? PREFIX : DIGITS;
        first_idx_s   = first_index(s_data);
        first_byte_s  = pos_byte(first_state_s, first_idx_s, 1'b0, s_data);
    end

    // Position following the current one (only used when the current byte
    // is not the last, so DIGITS at index 0 always has a terminator next).
    always_comb begin
        adv_state_s = state_r;
        adv_idx_s   = idx_r;
        adv_sub_s   = sub_r;
        case (state_r)
            PREFIX: begin
                if (!sub_r) begin
                    adv_sub_s = 1'b1;
                end else begin
                    adv_state_s = DIGITS;
                    adv_sub_s   = 1'b0;
                end
            end
            DIGITS: begin
                if (idx_r != '0) begin
                    adv_idx_s = idx_r - IW'(1);
                end else begin
                    adv_state_s = TERM;
                    adv_sub_s   = 1'b0;
                end
            end
            TERM:    adv_sub_s   = 1'b1;
            default: adv_state_s = IDLE;
        endcase
        adv_byte_s = pos_byte(adv_state_s, adv_idx_s, adv_sub_s, word_r);
    end

    // Sequencer: accepts words, walks the byte positions on each handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            word_r     <= '0;
            idx_r      <= '0;
            sub_r      <= 1'b0;
            s_ready_r  <= 1'b0;
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 8'h00;
            m_tlast_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (s_valid && s_ready_r) begin
                        word_r     <= s_data;
                        state_r    <= first_state_s;
                        idx_r      <= first_idx_s;
                        sub_r      <= 1'b0;
                        s_ready_r  <= 1'b0;
                        m_tvalid_r <= 1'b1;
                        m_tdata_r  <= first_byte_s[7:0];
                        m_tlast_r  <= first_byte_s[8];
                        busy_r     <= 1'b1;
                    end else begin
                        s_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    if (m_tvalid_r && m_tready) begin
                        if (m_tlast_r) begin
                            state_r    <= IDLE;
                            idx_r      <= '0;
                            sub_r      <= 1'b0;
                            m_tvalid_r <= 1'b0;
                            m_tlast_r  <= 1'b0;
                            s_ready_r  <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            state_r    <= adv_state_s;
                            idx_r      <= adv_idx_s;
                            sub_r      <= adv_sub_s;
                            m_tdata_r  <= adv_byte_s[7:0];
                            m_tlast_r  <= adv_byte_s[8];
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
            endcase
        end
    end

    assign s_ready  = s_ready_r;
    assign m_tvalid = m_tvalid_r;
    assign m_tdata  = m_tdata_r;
    assign m_tlast  = m_tlast_r;
    assign busy     = busy_r;

    hex_ascii_stream_encoder_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .m_tvalid (m_tvalid_r),
        .m_tready (m_tready),
        .m_tdata  (m_tdata_r),
        .m_tlast  (m_tlast_r)
    );

endmodule

// ---------------------------------------------------------------------------
// hex_ascii_stream_encoder_chk
//   Protocol checker: a stalled output byte keeps valid, data and last.
// Ports: clk, reset, m_tvalid, m_tready, m_tdata, m_tlast (all inputs).
// ---------------------------------------------------------------------------
module hex_ascii_stream_encoder_chk (
    input logic       clk,
    input logic       reset,
    input logic       m_tvalid,
    input logic       m_tready,
    input logic [7:0] m_tdata,
    input logic       m_tlast
);

    // A byte offered but not taken must be re-offered unchanged.
    a_stall_stable: assert property (@(posedge clk) disable iff (reset)
        (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tlast)));

endmodule

// File: tb/tb_hex_ascii_stream_encoder.sv
// ---------------------------------------------------------------------------
// tb_hex_ascii_stream_encoder
//   Directed bench with five encoder configurations sharing clock, reset and
//   m_tready:
//     0: defaults (32-bit, lower case, no prefix, LF)
//     1: upper case, "0x" prefix, CR LF
//     2: leading-zero suppression
//     3: 8-bit, no terminator
//     4: 64-bit, no terminator
// ---------------------------------------------------------------------------
module tb_hex_ascii_stream_encoder;

    logic             clk;
    logic             reset;
    logic             m_tready;
    logic [4:0]       s_valid_v;
    logic [4:0]       s_ready_v;
    logic [4:0]       m_tvalid_v;
    logic [4:0]       m_tlast_v;
    logic [4:0]       busy_v;
    logic [4:0][7:0]  m_tdata_v;
    logic [31:0]      s_data32;
    logic [7:0]       s_data8;
    logic [63:0]      s_data64;

    int tests;
    int fails;

    hex_ascii_stream_encoder u_def (
        .clk(clk), .reset(reset), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]),
        .s_data(s_data32), .m_tvalid(m_tvalid_v[0]), .m_tdata(m_tdata_v[0]),
        .m_tlast(m_tlast_v[0]), .m_tready(m_tready), .busy(busy_v[0]));

    hex_ascii_stream_encoder #(.UPPERCASE(1), .PREFIX_EN(1), .TERM_MODE(2)) u_cfg (
        .clk(clk), .reset(reset), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]),
        .s_data(s_data32), .m_tvalid(m_tvalid_v[1]), .m_tdata(m_tdata_v[1]),
        .m_tlast(m_tlast_v[1]), .m_tready(m_tready), .busy(busy_v[1]));

    hex_ascii_stream_encoder #(.ZERO_SUPPRESS(1)) u_zs (
        .clk(clk), .reset(reset), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]),
        .s_data(s_data32), .m_tvalid(m_tvalid_v[2]), .m_tdata(m_tdata_v[2]),
        .m_tlast(m_tlast_v[2]), .m_tready(m_tready), .busy(busy_v[2]));

    hex_ascii_stream_encoder #(.DATA_WIDTH(8), .TERM_MODE(0)) u_w8 (
        .clk(clk), .reset(reset), .s_valid(s_valid_v[3]), .s_ready(s_ready_v[3]),
        .s_data(s_data8), .m_tvalid(m_tvalid_v[3]), .m_tdata(m_tdata_v[3]),
        .m_tlast(m_tlast_v[3]), .m_tready(m_tready), .busy(busy_v[3]));

    hex_ascii_stream_encoder #(.DATA_WIDTH(64), .TERM_MODE(0)) u_w64 (
        .clk(clk), .reset(reset), .s_valid(s_valid_v[4]), .s_ready(s_ready_v[4]),
        .s_data(s_data64), .m_tvalid(m_tvalid_v[4]), .m_tdata(m_tdata_v[4]),
        .m_tlast(m_tlast_v[4]), .m_tready(m_tready), .busy(busy_v[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks the idle outputs of instance k.
    task automatic check_idle(input int k, input logic exp_ready);
        check($sformatf("idle_tvalid%0d", k), m_tvalid_v[k], 1'b0);
        check($sformatf("idle_tlast%0d", k),  m_tlast_v[k], 1'b0);
        check($sformatf("idle_busy%0d", k),   busy_v[k], 1'b0);
        check($sformatf("idle_ready%0d", k),  s_ready_v[k], exp_ready);
    endtask

    // Sends word d to instance k and checks the byte stream against exp.
    // bp: random backpressure, with a second request held pending.
    // abort_n: stop after that many bytes (0 = full sequence).
    task automatic send_word(input int k, input logic [63:0] d, input string exp,
                             input bit bp, input int abort_n);
        int   got;
        int   cyc;
        bit   stalled;
        bit   done;
        logic [7:0] pd;
        logic       pl;
        s_data32 = d[31:0];
        s_data8  = d[7:0];
        s_data64 = d;
        cyc = 0;
        while (!s_ready_v[k] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("ready_before", s_ready_v[k], 1'b1);
        s_valid_v[k] = 1'b1;
        @(negedge clk);
        s_valid_v[k] = bp;
        s_data32 = 32'hFFFF_FFFF;
        s_data8  = 8'hFF;
        s_data64 = 64'hFFFF_FFFF_FFFF_FFFF;
        check("ready_drop", s_ready_v[k], 1'b0);
        got = 0; cyc = 0; stalled = 1'b0; done = 1'b0; pd = 8'h00; pl = 1'b0;
        while (!done && cyc < 200) begin
            check("tvalid_held", m_tvalid_v[k], 1'b1);
            check("busy_held", busy_v[k], 1'b1);
            check("ready_low", s_ready_v[k], 1'b0);
            if (stalled) begin
                check("stall_data", m_tdata_v[k], pd);
                check("stall_last", m_tlast_v[k], pl);
            end
            m_tready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (m_tvalid_v[k] && m_tready) begin
                check($sformatf("byte%0d", got), m_tdata_v[k], exp[got]);
                check($sformatf("last%0d", got), m_tlast_v[k], (got == exp.len() - 1));
                got++;
                stalled = 1'b0;
                if (got == exp.len() || got == abort_n) begin
                    done = 1'b1;
                    s_valid_v[k] = 1'b0;
                end
            end else begin
                stalled = m_tvalid_v[k];
                pd = m_tdata_v[k];
                pl = m_tlast_v[k];
            end
            if (!done) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("seq_done", done, 1'b1);
        if (abort_n == 0) begin
            @(negedge clk);
            check_idle(k, 1'b1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        m_tready = 1'b0;
        s_valid_v = 5'b0;
        s_data32 = 32'h0;
        s_data8 = 8'h0;
        s_data64 = 64'h0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check_idle(k, 1'b0);
            check($sformatf("rst_tdata%0d", k), m_tdata_v[k], 8'h00);
        end
        reset = 1'b0;
        #1;
        check("ready_after_release", s_ready_v[0], 1'b0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check_idle(k, 1'b1);
        end

        send_word(0, 64'hDEAD_BEEF, "deadbeef\n", 1'b0, 0);
        send_word(1, 64'h0000_ABCD, "0x0000ABCD\015\012", 1'b0, 0);
        send_word(2, 64'h0000_0F00, "f00\n", 1'b0, 0);
        send_word(2, 64'h0000_0000, "0\n", 1'b0, 0);
        send_word(0, 64'h1234_5678, "12345678\n", 1'b1, 0);
        send_word(3, 64'h7E, "7e", 1'b0, 0);
        send_word(4, 64'h0123_4567_89AB_CDEF, "0123456789abcdef", 1'b0, 0);

        // Abort mid-sequence with an asynchronous reset.
        send_word(0, 64'hCAFE_F00D, "cafef00d\n", 1'b0, 3);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_idle(0, 1'b0);
        check("abort_tdata", m_tdata_v[0], 8'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ready_rise", s_ready_v[0], 1'b1);
        send_word(0, 64'h1111_1111, "11111111\n", 1'b0, 0);
        repeat (3) @(negedge clk);
        check_idle(0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
